vram_port_arbiter: RTL and testbench
====================================

# vram_port_arbiter

Shares one MIG user command port of the DDR2 video RAM between the display read path and the Mandelbrot render write path, and owns the double-buffered frame selection. Translates per-requester frame-relative offsets into absolute byte addresses (front buffer for reads, back buffer for writes), issues MIG commands, and swaps buffers at vertical sync once the renderer reports a finished frame. Sits between the renderer/display clients and the `videoRam` port in the `clk0` domain.

## Interface
- FRAME0_BASE, 30'd0, byte address of frame buffer 0
- FRAME1_BASE, 30'd70560, byte address of frame buffer 1
- STARVE_LIMIT, 4, consecutive read grants allowed while a write is eligible (1..15)

- clk0  in  1  MIG user clock; all logic on rising edge
- nreset  in  1  synchronous, active-low reset
- calib_done  in  1  MIG calibration done, asynchronous; double-flopped internally
- rd_req  in  1  display requests a read burst
- rd_offset  in  30  read byte offset within frame
- rd_bl  in  6  read burst length minus one (MIG encoding)
- rd_ack  out  1  one-cycle pulse: read command issued
- wr_req  in  1  renderer requests a write burst
- wr_offset  in  30  write byte offset within frame
- wr_bl  in  6  write burst length minus one
- wr_ack  out  1  one-cycle pulse: write command issued
- wr_fifo_count  in  7  MIG write FIFO occupancy (words)
- cmd_full  in  1  MIG command FIFO full
- cmd_en  out  1  MIG command strobe
- cmd_instr  out  3  3'b000 write, 3'b001 read
- cmd_bl  out  6  burst length minus one
- cmd_byte_addr  out  30  absolute byte address
- render_done  in  1  pulse: renderer finished back-buffer frame
- vsync  in  1  pulse: display at vertical blank
- front_sel  out  1  0: display reads FRAME0, renderer writes FRAME1; 1: swapped
- swap_pending  out  1  finished frame waiting for vsync
- render_go  out  1  one-cycle pulse: renderer may start next frame

## Operation
- States: WAIT_CAL, IDLE, ISSUE, GAP.
- WAIT_CAL: no grants; when synced calib_done=1 -> IDLE and pulse render_go once (first entry after reset only).
- IDLE decision: read eligible = rd_req. Write eligible = wr_req && !swap_pending && wr_fifo_count >= wr_bl+1 (7-bit compare). No decision while cmd_full=1.
- Priority: read wins unless starve counter == STARVE_LIMIT and write eligible, then write wins. Counter increments (saturating) on each read grant while write eligible; clears on write grant.
- On grant: register cmd_instr, cmd_bl = req bl, cmd_byte_addr = base + offset (mod 2^30; read base = front, write base = back) -> ISSUE.
- ISSUE: cmd_en=1 and matching ack=1 for exactly one cycle -> GAP.
- GAP: all strobes 0 -> IDLE; if synced calib_done=0 -> WAIT_CAL instead.
- Swap: render_done sets swap_pending. On vsync with swap_pending (or render_done in same cycle): toggle front_sel, clear swap_pending, pulse render_go next cycle. vsync without pending: no effect. render_done while pending: ignored.
- Swap may occur in any state; an already-registered command keeps its computed address.

## Timing
- Reset (nreset=0 at edge): state WAIT_CAL, cmd_en=0, cmd_instr=0, cmd_bl=0, cmd_byte_addr=0, rd_ack=0, wr_ack=0, front_sel=0, swap_pending=0, render_go=0, starve counter=0, calib sync=0. Reset mid-burst drops the command (cmd_en 0 next edge).
- Grant decision in cycle T -> cmd_en/ack high in T+1 -> GAP T+2 -> next decision T+3. Max one command per 3 cycles.
- Requester holds req, offset, bl stable until ack; may change them the cycle after ack.
- calib_done to first grant: 2 sync cycles + 1.
- render_go lags vsync by 1 cycle.

## Test plan
- Reset/calibration: hold nreset=0, then calib_done=1 -> all outputs 0 until WAIT_CAL exits; render_go single pulse 3 cycles after calib_done rises.
- Single read: front_sel=0, rd_req, rd_offset=0x100, rd_bl=15 -> cmd_en one cycle, instr=001, bl=15, addr=0x100, rd_ack coincident.
- Write gating: wr_req, wr_bl=7, wr_fifo_count=7 -> no grant; count=8 -> write with addr=70560+wr_offset, instr=000.
- Starvation: rd_req and eligible wr_req held high -> grant sequence R,R,R,R,W,R,R,R,R,W.
- Swap: render_done pulse then vsync 100 cycles later -> swap_pending high in between, writes blocked, front_sel=1 after vsync, render_go 1 cycle later, read addr now 70560+offset, write base 0.
- Boundaries: render_done and vsync same cycle -> immediate swap; cmd_full=1 with requests -> no cmd_en until cleared; nreset low in ISSUE -> cmd_en 0 next edge.

Source files
------------

// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: request, MIG command and frame-swap signals of the VRAM port arbiter.
// No logic; slave = arbiter side, master = clients plus MIG side.
// Requests are held by the master until the matching ack pulse.
interface vram_port_arbiter_if;
  logic        rd_req;
  logic [29:0] rd_offset;
  logic [5:0]  rd_bl;
  logic        rd_ack;
  logic        wr_req;
  logic [29:0] wr_offset;
  logic [5:0]  wr_bl;
  logic        wr_ack;
  logic [6:0]  wr_fifo_count;
  logic        cmd_full;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        render_done;
  logic        vsync;
  logic        front_sel;
  logic        swap_pending;
  logic        render_go;

  modport slave (
    input  rd_req, rd_offset, rd_bl, wr_req, wr_offset, wr_bl, wr_fifo_count,
           cmd_full, render_done, vsync,
    output rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
           front_sel, swap_pending, render_go
  );

  modport master (
    output rd_req, rd_offset, rd_bl, wr_req, wr_offset, wr_bl, wr_fifo_count,
           cmd_full, render_done, vsync,
    input  rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr,
           front_sel, swap_pending, render_go
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one MIG command port between display reads and render writes, owns double-buffer swap.
// Latency: decision cycle T -> cmd_en/ack in T+1 -> gap T+2 -> next decision T+3.
// Backpressure: no decision while cmd_full; writes wait for enough write-FIFO data and no pending swap.
module vram_port_arbiter #(
  parameter logic [29:0] FRAME0_BASE  = 30'd0,
  parameter logic [29:0] FRAME1_BASE  = 30'd70560,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk0,
  input  logic               nreset,
  input  logic               calib_done,
  vram_port_arbiter_if.slave bus
);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE, GAP} state_t;

  state_t      state;
  logic        cal_meta;
  logic        cal_sync;
  logic        go_done;
  logic [3:0]  starve_cnt;
  logic        rd_elig;
  logic        wr_elig;
  logic        grant_any;
  logic        grant_wr;
  logic        swap_now;
  logic [6:0]  wr_need;
  logic [29:0] rd_base;
  logic [29:0] wr_base;

  // Two-flop synchroniser for the asynchronous MIG calibration flag.
  always_ff @(posedge clk0) begin
    if (!nreset) begin
      cal_meta <= 1'b0;
      cal_sync <= 1'b0;
    end else begin
      cal_meta <= calib_done;
      cal_sync <= cal_meta;
    end
  end

  // Eligibility, priority and buffer-base selection for the current cycle.
  always_comb begin
    wr_need   = {1'b0, bus.wr_bl} + 7'd1;
    rd_elig   = bus.rd_req;
    wr_elig   = bus.wr_req && !bus.swap_pending && (bus.wr_fifo_count >= wr_need);
    grant_any = (state == IDLE) && !bus.cmd_full && (rd_elig || wr_elig);
    // Reads win unless the writer has been passed over STARVE_LIMIT times in a row.
    grant_wr  = wr_elig && (!rd_elig || (starve_cnt == STARVE_MAX));
    rd_base   = bus.front_sel ? FRAME1_BASE : FRAME0_BASE;
    wr_base   = bus.front_sel ? FRAME0_BASE : FRAME1_BASE;
    // render_done in the vsync cycle counts as already pending.
    swap_now  = bus.vsync && (bus.swap_pending || bus.render_done);
  end

  // Command FSM plus frame-swap bookkeeping; all outputs registered.
  always_ff @(posedge clk0) begin
    if (!nreset) begin
      state             <= WAIT_CAL;
      bus.cmd_en        <= 1'b0;
      bus.cmd_instr     <= 3'b000;
      bus.cmd_bl        <= 6'd0;
      bus.cmd_byte_addr <= 30'd0;
      bus.rd_ack        <= 1'b0;
      bus.wr_ack        <= 1'b0;
      bus.front_sel     <= 1'b0;
      bus.swap_pending  <= 1'b0;
      bus.render_go     <= 1'b0;
      go_done           <= 1'b0;
      starve_cnt        <= 4'd0;
    end else begin
      bus.cmd_en    <= 1'b0;
      bus.rd_ack    <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.render_go <= swap_now;
      case (state)
        WAIT_CAL: begin
          if (cal_sync) begin
            state <= IDLE;
            // Only the first calibration after reset kicks off the renderer.
            if (!go_done) begin
              bus.render_go <= 1'b1;
              go_done       <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (grant_any) begin
            state      <= ISSUE;
            bus.cmd_en <= 1'b1;
            if (grant_wr) begin
              bus.cmd_instr     <= 3'b000;
              bus.cmd_bl        <= bus.wr_bl;
              bus.cmd_byte_addr <= wr_base + bus.wr_offset;
              bus.wr_ack        <= 1'b1;
              starve_cnt        <= 4'd0;
            end else begin
              bus.cmd_instr     <= 3'b001;
              bus.cmd_bl        <= bus.rd_bl;
              bus.cmd_byte_addr <= rd_base + bus.rd_offset;
              bus.rd_ack        <= 1'b1;
              if (wr_elig && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        ISSUE:   state <= GAP;
        GAP:     state <= cal_sync ? IDLE : WAIT_CAL;
        default: state <= WAIT_CAL;
      endcase
      if (swap_now) begin
        bus.front_sel    <= ~bus.front_sel;
        bus.swap_pending <= 1'b0;
      end else if (bus.render_done) begin
        bus.swap_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed scenarios plus random traffic against a cycle-count reference model.
// Model predicts outputs per edge; compared on every falling edge.
// Requesters hold requests until ack, then may change them.
module tb_vram_port_arbiter;
  localparam logic [29:0] F0  = 30'd0;
  localparam logic [29:0] F1  = 30'd70560;
  localparam int          LIM = 4;

  logic clk0 = 1'b0;
  logic nreset = 1'b0;
  logic calib_done = 1'b0;

  vram_port_arbiter_if bus();

  vram_port_arbiter #(.FRAME0_BASE(F0), .FRAME1_BASE(F1), .STARVE_LIMIT(LIM)) dut (
    .clk0       (clk0),
    .nreset     (nreset),
    .calib_done (calib_done),
    .bus        (bus)
  );

  always #5 clk0 = ~clk0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time-based view: decisions allowed from cycle m_next_ok on; a grant at
  // edge c shows the command after c, blocks decisions until c+3, and at c+2
  // the calibration flag is re-examined.
  bit          m_started = 0;
  int          cyc = 0;
  logic [1:0]  m_hist;
  bit          m_ready, m_go_done, m_front, m_pend;
  int          m_starve, m_next_ok, m_gap_at;
  logic        e_cmd_en, e_rd_ack, e_wr_ack, e_go;
  logic [2:0]  e_instr;
  logic [5:0]  e_bl;
  logic [29:0] e_addr;

  task automatic model_step();
    bit syncv, rd_e, wr_e, pick_w, go;
    if (!nreset) begin
      m_started = 1;
      m_hist = 2'b00; m_ready = 0; m_go_done = 0; m_front = 0; m_pend = 0;
      m_starve = 0; m_next_ok = 0; m_gap_at = -1;
      e_cmd_en = 0; e_rd_ack = 0; e_wr_ack = 0; e_go = 0;
      e_instr = 3'd0; e_bl = 6'd0; e_addr = 30'd0;
    end else if (m_started) begin
      syncv  = m_hist[1];
      m_hist = {m_hist[0], calib_done};
      e_cmd_en = 0; e_rd_ack = 0; e_wr_ack = 0; go = 0;
      if (!m_ready) begin
        if (syncv) begin
          m_ready = 1;
          m_next_ok = cyc + 1;
          if (!m_go_done) begin go = 1; m_go_done = 1; end
        end
      end else if (cyc == m_gap_at) begin
        if (!syncv) m_ready = 0;
      end else if (cyc >= m_next_ok && !bus.cmd_full) begin
        rd_e = bus.rd_req;
        wr_e = bus.wr_req && !m_pend && (int'(bus.wr_fifo_count) >= int'(bus.wr_bl) + 1);
        if (rd_e || wr_e) begin
          pick_w = wr_e && (!rd_e || m_starve == LIM);
          if (pick_w) begin
            e_instr = 3'd0; e_bl = bus.wr_bl;
            e_addr = (m_front ? F0 : F1) + bus.wr_offset;
            e_wr_ack = 1; m_starve = 0;
          end else begin
            e_instr = 3'd1; e_bl = bus.rd_bl;
            e_addr = (m_front ? F1 : F0) + bus.rd_offset;
            e_rd_ack = 1;
            if (wr_e && m_starve < LIM) m_starve++;
          end
          e_cmd_en = 1;
          m_next_ok = cyc + 3;
          m_gap_at = cyc + 2;
        end
      end
      if (bus.vsync && (m_pend || bus.render_done)) begin
        m_front = !m_front; m_pend = 0; go = 1;
      end else if (bus.render_done) begin
        m_pend = 1;
      end
      e_go = go;
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk0);
    model_step();
  end

  // Single compare process: every falling edge once the model is running.
  initial forever begin
    @(negedge clk0);
    if (m_started) begin
      check("cmd_en",        bus.cmd_en,        e_cmd_en);
      check("rd_ack",        bus.rd_ack,        e_rd_ack);
      check("wr_ack",        bus.wr_ack,        e_wr_ack);
      check("cmd_instr",     bus.cmd_instr,     e_instr);
      check("cmd_bl",        bus.cmd_bl,        e_bl);
      check("cmd_byte_addr", bus.cmd_byte_addr, e_addr);
      check("front_sel",     bus.front_sel,     m_front);
      check("swap_pending",  bus.swap_pending,  m_pend);
      check("render_go",     bus.render_go,     e_go);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic wait_cmd(input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick(1);
      if (bus.cmd_en) seen = 1;
    end
  endtask

  initial begin
    bit          seen, rd_ack_prev, wr_ack_prev;
    int          cnt, go_at, go_cnt, n, drop;
    logic [9:0]  seq;

    bus.rd_req = 0; bus.rd_offset = '0; bus.rd_bl = '0;
    bus.wr_req = 0; bus.wr_offset = '0; bus.wr_bl = '0; bus.wr_fifo_count = '0;
    bus.cmd_full = 0; bus.render_done = 0; bus.vsync = 0;

    // Reset values.
    tick(3);
    check("rst_cmd_en", bus.cmd_en, 0);
    check("rst_front_sel", bus.front_sel, 0);
    check("rst_render_go", bus.render_go, 0);
    check("rst_swap_pending", bus.swap_pending, 0);
    check("rst_addr", bus.cmd_byte_addr, 0);

    // Calibration: render_go exactly once, three cycles after calib_done rises.
    nreset = 1; tick(2);
    calib_done = 1;
    go_at = 0; go_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (bus.render_go) begin go_cnt++; if (go_at == 0) go_at = i; end
    end
    check("cal_go_cycle", go_at, 3);
    check("cal_go_count", go_cnt, 1);

    // Single read from front buffer 0.
    bus.rd_offset = 30'h100; bus.rd_bl = 6'd15; bus.rd_req = 1;
    wait_cmd(20, seen);
    check("rd_seen", seen, 1);
    check("rd_instr", bus.cmd_instr, 1);
    check("rd_bl", bus.cmd_bl, 15);
    check("rd_addr", bus.cmd_byte_addr, 30'h100);
    check("rd_ack", bus.rd_ack, 1);
    tick(1); bus.rd_req = 0;
    check("rd_one_cycle", bus.cmd_en, 0);

    // Write gating on write-FIFO occupancy.
    bus.wr_offset = 30'h40; bus.wr_bl = 6'd7; bus.wr_fifo_count = 7'd7; bus.wr_req = 1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(1); if (bus.cmd_en) cnt++; end
    check("wr_gate_blocked", cnt, 0);
    bus.wr_fifo_count = 7'd8;
    wait_cmd(20, seen);
    check("wr_seen", seen, 1);
    check("wr_instr", bus.cmd_instr, 0);
    check("wr_bl", bus.cmd_bl, 7);
    check("wr_addr", bus.cmd_byte_addr, 30'd70624);
    check("wr_ack", bus.wr_ack, 1);
    tick(1); bus.wr_req = 0;

    // Starvation: fresh counter, both requesters held.
    nreset = 0; tick(2); nreset = 1;
    bus.rd_req = 1; bus.rd_bl = 6'd3;
    bus.wr_req = 1; bus.wr_bl = 6'd3; bus.wr_fifo_count = 7'd127;
    seq = '0; n = 0;
    for (int i = 0; i < 200 && n < 10; i++) begin
      tick(1);
      if (bus.cmd_en) begin seq[n] = bus.wr_ack; n++; end
    end
    check("starve_grants", n, 10);
    check("starve_seq", seq, 10'h210);
    tick(1); bus.rd_req = 0; bus.wr_req = 0;

    // Swap: pending blocks writes until vsync.
    tick(2);
    bus.render_done = 1; tick(1); bus.render_done = 0;
    check("swap_pending_set", bus.swap_pending, 1);
    bus.wr_offset = 30'h200; bus.wr_req = 1;
    cnt = 0; drop = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (bus.cmd_en) cnt++;
      if (!bus.swap_pending) drop++;
    end
    check("swap_wr_blocked", cnt, 0);
    check("swap_pending_held", drop, 0);
    bus.vsync = 1; tick(1); bus.vsync = 0;
    check("swap_front", bus.front_sel, 1);
    check("swap_go", bus.render_go, 1);
    check("swap_pending_clr", bus.swap_pending, 0);
    tick(1);
    check("swap_go_end", bus.render_go, 0);
    check("swap_wr_ack", bus.wr_ack, 1);
    check("swap_wr_addr", bus.cmd_byte_addr, 30'h200);
    tick(1); bus.wr_req = 0;
    bus.rd_offset = 30'h100; bus.rd_req = 1;
    wait_cmd(20, seen);
    check("swap_rd_seen", seen, 1);
    check("swap_rd_addr", bus.cmd_byte_addr, 30'd70816);
    tick(1); bus.rd_req = 0;

    // render_done and vsync together swap immediately.
    tick(3);
    bus.render_done = 1; bus.vsync = 1; tick(1); bus.render_done = 0; bus.vsync = 0;
    check("same_front", bus.front_sel, 0);
    check("same_pending", bus.swap_pending, 0);
    check("same_go", bus.render_go, 1);

    // cmd_full stalls all decisions.
    bus.cmd_full = 1; bus.rd_offset = 30'h10; bus.rd_req = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(1); if (bus.cmd_en) cnt++; end
    check("full_blocked", cnt, 0);
    bus.cmd_full = 0;
    wait_cmd(10, seen);
    check("full_release", seen, 1);
    check("full_addr", bus.cmd_byte_addr, 30'h10);
    tick(1); bus.rd_req = 0;

    // Reset while a command is issuing drops it.
    tick(2);
    bus.rd_offset = 30'h55; bus.rd_req = 1;
    wait_cmd(10, seen);
    check("rstiss_seen", seen, 1);
    nreset = 0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (bus.cmd_en) cnt++; end
    check("rstiss_cmd_en", cnt, 0);
    check("rstiss_addr", bus.cmd_byte_addr, 0);
    bus.rd_req = 0; nreset = 1;

    // Random traffic checked by the model.
    rd_ack_prev = 0; wr_ack_prev = 0;
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      if (rd_ack_prev || (!bus.rd_req && $urandom_range(0, 3) == 0)) begin
        bus.rd_req    = ($urandom_range(0, 1) == 1);
        bus.rd_offset = 30'($urandom);
        bus.rd_bl     = 6'($urandom_range(0, 63));
      end
      if (wr_ack_prev || (!bus.wr_req && $urandom_range(0, 3) == 0)) begin
        bus.wr_req    = ($urandom_range(0, 1) == 1);
        bus.wr_offset = 30'($urandom);
        bus.wr_bl     = 6'($urandom_range(0, 63));
      end
      rd_ack_prev = bus.rd_ack;
      wr_ack_prev = bus.wr_ack;
      bus.wr_fifo_count = 7'($urandom_range(0, 90));
      bus.cmd_full      = ($urandom_range(0, 4) == 0);
      bus.render_done   = ($urandom_range(0, 29) == 0);
      bus.vsync         = ($urandom_range(0, 39) == 0);
      if (calib_done && $urandom_range(0, 299) == 0) calib_done = 0;
      else if (!calib_done && $urandom_range(0, 9) == 0) calib_done = 1;
      nreset = ($urandom_range(0, 599) != 0);
    end
    nreset = 1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
